piso_tx: RTL and testbench

Parallel-in serial-out transmitter. It accepts an N-bit word over a valid/ready handshake and shifts the word out one bit at a time on a serial line. A frame strobe marks the bits of the word, and each bit is held for a programmable number of clock cycles. It is the sending end for the team's serial-in shift-register receivers: a receiver sampling sdata once per bit while sframe is high reassembles the word.

---
 rtl/piso_pkg.sv | 12 +
 rtl/piso_tx_bit_tick_gen.sv | 36 +++
 rtl/piso_tx.sv | 110 +++++++++++
 tb/tb_piso_tx.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Shared types and constants for the parallel-in serial-out transmitter.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int LSB_FIRST = 0;
  localparam int MSB_FIRST = 1;

endpackage

// File: rtl/piso_tx_bit_tick_gen.sv
// Bit-period counter: emits a tick on the last clock cycle of each serial bit.
module bit_tick_gen #(
  parameter int BIT_CYC = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);
  import piso_pkg::*;

  localparam int CW = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(BIT_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // With BIT_CYC=1 LAST is zero, the count never leaves zero and the tick is constant high.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      if (cnt_q == LAST) cnt_d = '0;
      else               cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter with valid/ready input and framed serial output.
module piso_tx #(
  parameter int N         = 8,
  parameter int BIT_CYC   = 1,
  parameter int MSB_FIRST = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         s_valid,
  input  logic [N-1:0] s_data,
  output logic         s_ready,
  output logic         sdata,
  output logic         sframe,
  output logic         tx_done
);
  import piso_pkg::*;

  localparam int BW = $clog2(N);
  localparam logic [BW-1:0] LAST_BIT = BW'(N - 1);
  localparam bit MSB_ORDER = (MSB_FIRST == piso_pkg::MSB_FIRST);

  state_t         state_q, state_d;
  logic [N-1:0]   sr_q, sr_d, sr_shift;
  logic [BW-1:0]  bitcnt_q, bitcnt_d;
  logic           sdata_q, sdata_d;
  logic           sframe_q, sframe_d;
  logic           tx_done_q, tx_done_d;
  logic           hs, in_shift, tick, adv, last;

  function automatic logic first_bit(input logic [N-1:0] v);
    return MSB_ORDER ? v[N-1] : v[0];
  endfunction

  assign in_shift = (state_q == SHIFT);
  assign hs       = s_valid & (state_q == IDLE);
  assign adv      = in_shift & tick;
  assign last     = adv & (bitcnt_q == LAST_BIT);
  assign sr_shift = MSB_ORDER ? {sr_q[N-2:0], 1'b0} : {1'b0, sr_q[N-1:1]};

  bit_tick_gen #(
    .BIT_CYC (BIT_CYC)
  ) u_tick (
    .clk_i  (clk),
    .rst_i  (reset),
    .en_i   (in_shift),
    .clr_i  (hs),
    .tick_o (tick)
  );

  // sdata is registered, so it is loaded with the bit that will be current after the edge.
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    bitcnt_d  = bitcnt_q;
    sdata_d   = sdata_q;
    sframe_d  = sframe_q;
    tx_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        sdata_d  = 1'b0;
        sframe_d = 1'b0;
        if (hs) begin
          state_d  = SHIFT;
          sr_d     = s_data;
          bitcnt_d = '0;
          sdata_d  = first_bit(s_data);
          sframe_d = 1'b1;
        end
      end
      SHIFT: begin
        if (last) begin
          state_d   = IDLE;
          bitcnt_d  = '0;
          sdata_d   = 1'b0;
          sframe_d  = 1'b0;
          tx_done_d = 1'b1;
        end else if (adv) begin
          sr_d     = sr_shift;
          bitcnt_d = bitcnt_q + 1'b1;
          sdata_d  = first_bit(sr_shift);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      sr_q      <= '0;
      bitcnt_q  <= '0;
      sdata_q   <= 1'b0;
      sframe_q  <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bitcnt_q  <= bitcnt_d;
      sdata_q   <= sdata_d;
      sframe_q  <= sframe_d;
      tx_done_q <= tx_done_d;
    end
  end

  assign s_ready = (state_q == IDLE);
  assign sdata   = sdata_q;
  assign sframe  = sframe_q;
  assign tx_done = tx_done_q;

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx: LSB/MSB order, multi-cycle bits, back-to-back, stall and reset abort.
module tb_piso_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] d;
  logic [2:0] vld, rdy, sd, sf, td;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // unit 0: LSB-first 1 cycle/bit, unit 1: MSB-first 1 cycle/bit, unit 2: LSB-first 4 cycles/bit
  piso_tx #(.N(8), .BIT_CYC(1), .MSB_FIRST(0)) dut_l (
    .clk(clk), .reset(reset), .s_valid(vld[0]), .s_data(d),
    .s_ready(rdy[0]), .sdata(sd[0]), .sframe(sf[0]), .tx_done(td[0]));
  piso_tx #(.N(8), .BIT_CYC(1), .MSB_FIRST(1)) dut_m (
    .clk(clk), .reset(reset), .s_valid(vld[1]), .s_data(d),
    .s_ready(rdy[1]), .sdata(sd[1]), .sframe(sf[1]), .tx_done(td[1]));
  piso_tx #(.N(8), .BIT_CYC(4), .MSB_FIRST(0)) dut_4 (
    .clk(clk), .reset(reset), .s_valid(vld[2]), .s_data(d),
    .s_ready(rdy[2]), .sdata(sd[2]), .sframe(sf[2]), .tx_done(td[2]));

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input logic [1:0] u, input string tag);
    chk({tag, ".s_ready"}, rdy[u], 1'b1);
    chk({tag, ".sdata"},   sd[u],  1'b0);
    chk({tag, ".sframe"},  sf[u],  1'b0);
    chk({tag, ".tx_done"}, td[u],  1'b0);
  endtask

  // Starts just after the handshake edge; ends just after the edge that raises tx_done.
  task automatic check_bits(input logic [1:0] u, input logic [7:0] w, input int bc,
                            input bit msb, input string tag);
    logic [7:0] t;
    t = w;
    for (int b = 0; b < 8; b++) begin
      for (int c = 0; c < bc; c++) begin
        chk({tag, ".sdata"},   sd[u],  msb ? t[7] : t[0]);
        chk({tag, ".sframe"},  sf[u],  1'b1);
        chk({tag, ".s_ready"}, rdy[u], 1'b0);
        chk({tag, ".tx_done"}, td[u],  1'b0);
        step();
      end
      t = msb ? (t << 1) : (t >> 1);
    end
    chk({tag, ".done_hi"},  td[u],  1'b1);
    chk({tag, ".end_frm"},  sf[u],  1'b0);
    chk({tag, ".end_sd"},   sd[u],  1'b0);
    chk({tag, ".end_rdy"},  rdy[u], 1'b1);
  endtask

  task automatic run_frame(input logic [1:0] u, input logic [7:0] w, input int bc,
                           input bit msb, input string tag);
    vld[u] = 1'b1;
    d      = w;
    step();
    vld[u] = 1'b0;
    check_bits(u, w, bc, msb, tag);
    step();
    chk_idle(u, {tag, ".after"});
  endtask

  initial begin
    reset = 1'b1;
    vld   = '0;
    d     = '0;
    step();
    step();
    for (int u = 0; u < 3; u++) chk_idle(2'(u), "reset");
    reset = 1'b0;
    step();
    for (int u = 0; u < 3; u++) chk_idle(2'(u), "post_reset");

    // 8'hC1 LSB-first: 1,0,0,0,0,0,1,1
    run_frame(2'd0, 8'hC1, 1, 1'b0, "lsb_c1");
    // 8'hC1 MSB-first: 1,1,0,0,0,0,0,1
    run_frame(2'd1, 8'hC1, 1, 1'b1, "msb_c1");
    // 8'h81 with each bit held 4 cycles
    run_frame(2'd2, 8'h81, 4, 1'b0, "bc4_81");

    // Back-to-back: s_valid held high, second word accepted in the tx_done cycle
    vld[0] = 1'b1;
    d      = 8'h3C;
    step();
    d      = 8'hA5;
    check_bits(2'd0, 8'h3C, 1, 1'b0, "b2b_3c");
    step();
    vld[0] = 1'b0;
    check_bits(2'd0, 8'hA5, 1, 1'b0, "b2b_a5");
    step();
    chk_idle(2'd0, "b2b_after");

    // Stall: 8'hFF offered mid-frame of 8'h00 must be ignored
    vld[0] = 1'b1;
    d      = 8'h00;
    step();
    vld[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) begin
        vld[0] = 1'b1;
        d      = 8'hFF;
      end
      if (i == 4) vld[0] = 1'b0;
      chk("stall.sdata",   sd[0],  1'b0);
      chk("stall.sframe",  sf[0],  1'b1);
      chk("stall.s_ready", rdy[0], 1'b0);
      step();
    end
    chk("stall.done_hi", td[0], 1'b1);
    step();
    chk_idle(2'd0, "stall_after");
    step();
    chk_idle(2'd0, "stall_after2");

    // Reset at bit 3 of 8'hFF aborts the word immediately
    vld[0] = 1'b1;
    d      = 8'hFF;
    step();
    vld[0] = 1'b0;
    step();
    step();
    step();
    chk("abort.pre_sdata",  sd[0], 1'b1);
    chk("abort.pre_sframe", sf[0], 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk_idle(2'd0, "abort_async");
    step();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk_idle(2'd0, "abort_release");
      step();
    end
    run_frame(2'd0, 8'h5A, 1, 1'b0, "post_abort_5a");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
